wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file writeback port A of PA_Core between three execution-unit requesters: 0 = ALU, 1 = MUL, 2 = LOAD.
- Grants one requester per cycle using round-robin priority and registers the winner onto wbAFinal_o / wbAddrAFinal_o / wbValAFinal_o.
- Sits between the execute-stage result buses and the register file.
- Also keeps a saturating count of cycles in which any requester was blocked.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 16, writeback data width.
- ZERO_DISCARD, 1, when 1, granted writes to address 0 are consumed but not driven to the port.

Ports:
- clock_i  in  1  core clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  3  per-requester write request; bit k = requester k.
- req_addr_i  in  3*ADDR_W  destination addresses; requester k at bits [k*ADDR_W +: ADDR_W].
- req_val_i  in  3*DATA_W  write values; requester k at bits [k*DATA_W +: DATA_W].
- req_ready_o  out  3  combinational grant/accept; one-hot or zero.
- wb_stall_i  in  1  register-file port busy; no grant may be issued this cycle.
- wbAFinal_o  out  1  registered writeback enable.
- wbAddrAFinal_o  out  ADDR_W  registered writeback address.
- wbValAFinal_o  out  DATA_W  registered writeback value.
- blocked_cnt_o  out  16  saturating count of cycles with at least one request not accepted.

Behaviour:
- Reset (reset_i=1 at a rising edge):
  - wbAFinal_o=0, wbAddrAFinal_o=0, wbValAFinal_o=0, blocked_cnt_o=0.
  - Round-robin pointer rr_ptr=0.
  - Reset overrides all requests in that cycle. No grant is registered.
  - req_ready_o is forced to 0 while reset_i=1.
- Handshake: a transfer occurs on requester k in a cycle where req_valid_i[k]=1 and req_ready_o[k]=1. A requester holds valid, addr and val stable until accepted.
- Grant selection (combinational):
  - If wb_stall_i=1 or no valid request, req_ready_o=0.
  - Otherwise scan requesters starting at rr_ptr, in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). The first one with valid=1 wins and only its req_ready_o bit is 1.
- Pointer update:
  - On a transfer by winner w, rr_ptr <= (w+1) mod 3. Encodings are 0,1,2; 3 is never reached.
  - With no transfer, rr_ptr is unchanged.
- Output register, latency 1 cycle from accept edge to port:
  - On a transfer: wbAddrAFinal_o <= winner addr and wbValAFinal_o <= winner val.
  - wbAFinal_o <= 1, except wbAFinal_o <= 0 when ZERO_DISCARD=1 and addr=0.
  - With no transfer: wbAFinal_o <= 0, and wbAddrAFinal_o / wbValAFinal_o hold their previous values.
  - wbAFinal_o is therefore a single-cycle pulse per accepted write.
  - Back-to-back grants give a continuous high on wbAFinal_o, with new addr/val each cycle.
- Blocked counter:
  - Increments by 1 in each cycle where (req_valid_i & ~req_ready_o) != 0. This includes stall cycles and losers of arbitration.
  - Saturates at 16'hFFFF; no wrap.
- Fairness: with all three requesters continuously valid and no stall, grants rotate 0,1,2,0,... Maximum wait for any valid requester is 2 grant cycles plus stall cycles.
- A request that drops valid before acceptance is simply not considered; no state is retained for it.
- Simultaneous transfer and stall cannot occur. A stall asserted in the same cycle as valid requests suppresses the grant entirely.

Test Plan:
- Reset: assert reset_i with all req_valid_i=3'b111 → next cycle wbAFinal_o=0, blocked_cnt_o=0, req_ready_o=3'b000; first cycle after reset deasserts grants requester 0.
- Single request: req 1 valid, addr=5'd7, val=16'hBEEF, no stall → req_ready_o=3'b010 that cycle; next cycle wbAFinal_o=1, wbAddrAFinal_o=7, wbValAFinal_o=16'hBEEF; following idle cycle wbAFinal_o=0 while addr/val are held.
- Round robin: all three valid for 6 cycles with distinct addrs 1,2,3 → grants 0,1,2,0,1,2; blocked_cnt_o increases by 6 (two losers each cycle count as one cycle).
- Stall: req 2 valid, wb_stall_i=1 for 3 cycles then 0 → no grant for 3 cycles, blocked_cnt_o=3; grant on the 4th cycle, wbAFinal_o=1 on the 5th.
- Zero discard: req 0 valid, addr=0, val=16'h1234 → req_ready_o[0]=1, next cycle wbAFinal_o=0, and rr_ptr advances so a subsequent 0+1 request grants requester 1.
- Saturation: hold req 0 valid with wb_stall_i=1 for 65540 cycles → blocked_cnt_o stays at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares register-file writeback port A between three execution-unit
//   requesters (0 = ALU, 1 = MUL, 2 = LOAD). One requester per cycle is
//   granted in round-robin order. The winner's address and value are
//   registered onto the final writeback port one cycle after acceptance.
//   A saturating counter tracks the cycles in which any request was left
//   waiting.
//
// Ports
//   clock_i         core clock, rising edge
//   reset_i         synchronous, active-high reset
//   req_valid_i     [3]          per-requester write request
//   req_addr_i      [3*ADDR_W]   requester k at [k*ADDR_W +: ADDR_W]
//   req_val_i       [3*DATA_W]   requester k at [k*DATA_W +: DATA_W]
//   req_ready_o     [3]          combinational accept, one-hot or zero
//   wb_stall_i                   port busy, suppresses any grant
//   wbAFinal_o                   registered writeback enable (1-cycle pulse)
//   wbAddrAFinal_o  [ADDR_W]     registered writeback address
//   wbValAFinal_o   [DATA_W]     registered writeback value
//   blocked_cnt_o   [16]         saturating count of cycles with a waiter
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 16,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [2:0]          req_valid_i,
  input  logic [3*ADDR_W-1:0] req_addr_i,
  input  logic [3*DATA_W-1:0] req_val_i,
  output logic [2:0]          req_ready_o,
  input  logic                wb_stall_i,
  output logic                wbAFinal_o,
  output logic [ADDR_W-1:0]   wbAddrAFinal_o,
  output logic [DATA_W-1:0]   wbValAFinal_o,
  output logic [15:0]         blocked_cnt_o
);

  // Round-robin pointer: index of the requester with highest priority.
  // Only encodings 0..2 are ever loaded.
  logic [1:0]        rrPtr;

  logic [2:0]        grant;
  logic              transfer;
  logic [1:0]        winner;
  logic              found;
  logic [2:0]        candSum;
  logic [1:0]        cand;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winVal;
  logic              anyBlocked;

  // ---------------------------------------------------------------------------
  // Grant selection: scan rrPtr, rrPtr+1, rrPtr+2 (mod 3); first valid wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    grant   = 3'b000;
    winner  = 2'd0;
    found   = 1'b0;
    candSum = 3'd0;
    cand    = 2'd0;
    if (!reset_i && !wb_stall_i) begin
      for (int i = 0; i < 3; i++) begin
        candSum = {1'b0, rrPtr} + 3'(i);
        cand    = (candSum >= 3'd3) ? 2'(candSum - 3'd3) : candSum[1:0];
        if (!found && req_valid_i[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
      if (found) begin
        grant[winner] = 1'b1;
      end
    end
  end

  assign req_ready_o = grant;
  assign transfer    = |grant;
  assign anyBlocked  = |(req_valid_i & ~grant);

  // Winner payload mux, constant slices only.
  always_comb begin
    winAddr = req_addr_i[0 +: ADDR_W];
    winVal  = req_val_i[0 +: DATA_W];
    case (winner)
      2'd1: begin
        winAddr = req_addr_i[ADDR_W +: ADDR_W];
        winVal  = req_val_i[DATA_W +: DATA_W];
      end
      2'd2: begin
        winAddr = req_addr_i[2*ADDR_W +: ADDR_W];
        winVal  = req_val_i[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State: pointer, output register, blocked counter.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rrPtr          <= 2'd0;
      wbAFinal_o     <= 1'b0;
      wbAddrAFinal_o <= '0;
      wbValAFinal_o  <= '0;
      blocked_cnt_o  <= 16'd0;
    end else begin
      if (transfer) begin
        rrPtr          <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
        wbAddrAFinal_o <= winAddr;
        wbValAFinal_o  <= winVal;
        // Writes to r0 are consumed (pointer advances) but never driven.
        wbAFinal_o     <= !(ZERO_DISCARD && (winAddr == '0));
      end else begin
        wbAFinal_o     <= 1'b0;
      end

      if (anyBlocked && (blocked_cnt_o != 16'hFFFF)) begin
        blocked_cnt_o <= blocked_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Directed-vector bench for wb_port_arbiter with hand-computed expectations.
//   Inputs change 1 ns after a rising edge; combinational ready is sampled
//   1 ns later, registered outputs 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic                clock_i = 1'b0;
  logic                reset_i;
  logic [2:0]          req_valid_i;
  logic [3*ADDR_W-1:0] req_addr_i;
  logic [3*DATA_W-1:0] req_val_i;
  logic [2:0]          req_ready_o;
  logic                wb_stall_i;
  logic                wbAFinal_o;
  logic [ADDR_W-1:0]   wbAddrAFinal_o;
  logic [DATA_W-1:0]   wbValAFinal_o;
  logic [15:0]         blocked_cnt_o;

  int nCompared   = 0;
  int nMismatched = 0;

  wb_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .ZERO_DISCARD (1'b1)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .req_valid_i    (req_valid_i),
    .req_addr_i     (req_addr_i),
    .req_val_i      (req_val_i),
    .req_ready_o    (req_ready_o),
    .wb_stall_i     (wb_stall_i),
    .wbAFinal_o     (wbAFinal_o),
    .wbAddrAFinal_o (wbAddrAFinal_o),
    .wbValAFinal_o  (wbValAFinal_o),
    .blocked_cnt_o  (blocked_cnt_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] valid, input logic stall,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input logic [ADDR_W-1:0] a2,
                       input logic [DATA_W-1:0] v0, input logic [DATA_W-1:0] v1,
                       input logic [DATA_W-1:0] v2);
    req_valid_i = valid;
    wb_stall_i  = stall;
    req_addr_i  = {a2, a1, a0};
    req_val_i   = {v2, v1, v0};
    #1;
  endtask

  task automatic checkOut(input string tag, input logic en,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] val);
    check({tag, ".en"},   32'(wbAFinal_o),     32'(en));
    check({tag, ".addr"}, 32'(wbAddrAFinal_o), 32'(addr));
    check({tag, ".val"},  32'(wbValAFinal_o),  32'(val));
  endtask

  // Bounded run: a hang is reported and stops the run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [2:0] rrExp [6];

  initial begin
    rrExp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // ---------------- Reset with all requesters valid ----------------
    reset_i = 1'b1;
    drive(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 16'hA001, 16'hA002, 16'hA003);
    check("rst.ready", 32'(req_ready_o), 32'(3'b000));
    tick();
    tick();
    check("rst.ready2", 32'(req_ready_o), 32'(3'b000));
    checkOut("rst", 1'b0, 5'd0, 16'h0000);
    check("rst.cnt", 32'(blocked_cnt_o), 32'd0);

    // ---------------- Round robin, 6 cycles ----------------
    reset_i = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr%0d.ready", i), 32'(req_ready_o), 32'(rrExp[i]));
      tick();
      checkOut($sformatf("rr%0d", i), 1'b1, 5'(i % 3 + 1), 16'(16'hA001 + (i % 3)));
    end
    check("rr.cnt", 32'(blocked_cnt_o), 32'd6);

    // Idle: enable drops, payload held.
    drive(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 16'h0, 16'h0);
    check("idle.ready", 32'(req_ready_o), 32'(3'b000));
    tick();
    checkOut("idle", 1'b0, 5'd3, 16'hA003);

    // ---------------- Single request on MUL ----------------
    drive(3'b010, 1'b0, 5'd0, 5'd7, 5'd0, 16'h0, 16'hBEEF, 16'h0);
    check("single.ready", 32'(req_ready_o), 32'(3'b010));
    tick();
    checkOut("single", 1'b1, 5'd7, 16'hBEEF);
    drive(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 16'h0, 16'h0);
    tick();
    checkOut("single.hold", 1'b0, 5'd7, 16'hBEEF);
    check("single.cnt", 32'(blocked_cnt_o), 32'd6);

    // ---------------- Stall: LOAD waits 3 cycles (rrPtr = 2) ----------------
    drive(3'b100, 1'b1, 5'd0, 5'd0, 5'd9, 16'h0, 16'h0, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d.ready", i), 32'(req_ready_o), 32'(3'b000));
      tick();
      check($sformatf("stall%0d.en", i), 32'(wbAFinal_o), 32'd0);
    end
    check("stall.cnt", 32'(blocked_cnt_o), 32'd9);
    wb_stall_i = 1'b0;
    #1;
    check("stall.release.ready", 32'(req_ready_o), 32'(3'b100));
    tick();
    checkOut("stall.release", 1'b1, 5'd9, 16'h2222);
    check("stall.release.cnt", 32'(blocked_cnt_o), 32'd9);

    // ---------------- Zero discard (rrPtr = 0) ----------------
    drive(3'b001, 1'b0, 5'd0, 5'd0, 5'd0, 16'h1234, 16'h0, 16'h0);
    check("zero.ready", 32'(req_ready_o), 32'(3'b001));
    tick();
    checkOut("zero", 1'b0, 5'd0, 16'h1234);
    // Pointer advanced to 1: MUL beats ALU.
    drive(3'b011, 1'b0, 5'd4, 5'd5, 5'd0, 16'h4444, 16'h5555, 16'h0);
    check("zero.next.ready", 32'(req_ready_o), 32'(3'b010));
    tick();
    checkOut("zero.next", 1'b1, 5'd5, 16'h5555);
    check("zero.next.cnt", 32'(blocked_cnt_o), 32'd10);
    // Pointer 2, LOAD idle: ALU wins via wraparound.
    drive(3'b001, 1'b0, 5'd4, 5'd0, 5'd0, 16'h4444, 16'h0, 16'h0);
    check("wrap.ready", 32'(req_ready_o), 32'(3'b001));
    tick();
    checkOut("wrap", 1'b1, 5'd4, 16'h4444);

    // Pointer 1, ALU and LOAD valid: order 1,2,0 so LOAD wins.
    drive(3'b101, 1'b0, 5'd10, 5'd0, 5'd12, 16'hAAAA, 16'h0, 16'hCCCC);
    check("order.ready", 32'(req_ready_o), 32'(3'b100));
    tick();
    checkOut("order", 1'b1, 5'd12, 16'hCCCC);
    check("order.cnt", 32'(blocked_cnt_o), 32'd11);

    // Pointer 0, MUL alone: pointer moves to 2.
    drive(3'b010, 1'b0, 5'd0, 5'd13, 5'd0, 16'h0, 16'hDDDD, 16'h0);
    check("ptr2.ready", 32'(req_ready_o), 32'(3'b010));
    tick();
    checkOut("ptr2", 1'b1, 5'd13, 16'hDDDD);

    // ---------------- Saturation: 65540 stalled cycles from 11 ----------------
    drive(3'b001, 1'b1, 5'd1, 5'd0, 5'd0, 16'h0101, 16'h0, 16'h0);
    check("sat.ready", 32'(req_ready_o), 32'(3'b000));
    for (int i = 0; i < 65523; i++) tick();
    check("sat.cnt.fffe", 32'(blocked_cnt_o), 32'hFFFE);
    tick();
    check("sat.cnt.ffff", 32'(blocked_cnt_o), 32'hFFFF);
    for (int i = 0; i < 16; i++) tick();
    check("sat.cnt.hold", 32'(blocked_cnt_o), 32'hFFFF);
    check("sat.en", 32'(wbAFinal_o), 32'd0);

    // ---------------- Reset restores pointer and counter ----------------
    reset_i = 1'b1;
    drive(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 16'hB001, 16'hB002, 16'hB003);
    check("rst2.ready", 32'(req_ready_o), 32'(3'b000));
    tick();
    check("rst2.cnt", 32'(blocked_cnt_o), 32'd0);
    checkOut("rst2", 1'b0, 5'd0, 16'h0000);
    reset_i = 1'b0;
    #1;
    check("rst2.first.ready", 32'(req_ready_o), 32'(3'b001));
    tick();
    checkOut("rst2.first", 1'b1, 5'd1, 16'hB001);
    check("rst2.first.cnt", 32'(blocked_cnt_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
